encoder: RTL and testbench
==========================

ENCODER -- requirements
Module: encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, fixed XGMII-side and PCS-side word width (DATA_NBYTES = 4 lanes).
REQ-002 SHALL have port i_txc  input  1  sole clock; one clock, all logic on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_init_done  input  1  PCS ready; low forces idle-hold (REQ-020).
REQ-005 SHALL have port i_txd  input  32  XGMII data, lane 0 = bits [7:0].
REQ-006 SHALL have port i_txctl  input  4  XGMII control, bit n for lane n.
REQ-007 SHALL have port i_tx_data_valid  input  1  gearbox advance; low = stall, all state frozen.
REQ-008 SHALL have port o_txd  output  32  encoded block half: low half (type byte first), then high half.
REQ-009 SHALL have port o_tx_header  output  2  sync header, meaningful when o_tx_header_valid.
REQ-010 SHALL have port o_tx_header_valid  output  1  high on low-half word of each 66b block.

Function
REQ-011 SHALL keep a phase bit: 0 = lanes 0-3 of 64b XGMII word, 1 = lanes 4-7; toggles on each i_tx_data_valid cycle.
REQ-012 SHALL register the phase-0 word and ctl; on phase 1 form 64b word {i_txd, held} and 8b ctl.
REQ-013 SHALL encode all-data words as header 2'b01, payload unchanged.
REQ-014 SHALL encode control words as header 2'b10 with type byte in bits [7:0]: IDLE 0x1E, O4 0x2D, S4 0x33, O0S4 0x66, O0O4 0x55, S0 0x78, O0 0x4B, T0..T7 0x87/0x99/0xAA/0xB4/0xCC/0xD2/0xE1/0xFF.
REQ-015 SHALL map XGMII control chars to 7b codes at bits [8+7i +: 7]: idle 0x07->0x00, error 0xFE->0x1E; sequence 0x9C -> 4b O-code 0x0; start 0xFB and terminate 0xFD consumed by type byte.
REQ-016 SHALL map any unencodable word (unknown char, illegal position, start not lane 0/4) to the error block: header 2'b10, type 0x1E, eight 0x1E codes.
REQ-017 SHALL register the encoded 66b block on the phase-1 valid cycle; emit low 32b with header and header_valid=1 on the next valid cycle, high 32b with header_valid=0 on the one after (latency: one 64b block, two valid cycles).
REQ-018 SHALL hold o_txd, o_tx_header, o_tx_header_valid unchanged while i_tx_data_valid is low.
REQ-019 SHALL implement sequence checker states TX_INIT, TX_C, TX_D, TX_T, TX_E classifying blocks C (idle/ordered), S, D, T, E: INIT->C on C, ->D on S, else E; C: C->C, S->D, else E; D: D->D, T->T, else E; T: C->C, S->D, else E; E: D->D, T->T, C->C, S->D, E->E; INIT/E output error block for any non-C/S/D/T-legal block.
REQ-020 SHALL, while i_init_done low, hold state TX_INIT, phase 0, outputs at reset values; first valid after rise is phase 0.

Reset
REQ-021 SHALL, on i_reset_n low, asynchronously clear o_txd to 0, o_tx_header to 2'b00, o_tx_header_valid to 0, phase to 0, held word/ctl to 0, state to TX_INIT.
REQ-022 SHALL, on reset mid-block, discard any half-received word; no partial block emitted after release.

Configuration
REQ-023 SHALL compile the REQ-019 sequence checker only when ENCODER_TX_SM_EN is defined.
REQ-024 SHALL, without ENCODER_TX_SM_EN, encode each block independently per REQ-013..016 with no state-based error substitution.

Verification
REQ-025 SHALL cover: reset, init_done=1, all-idle input (txd 0x07070707, ctl 0xF) -> header 2'b10, low word 0x0000001E, high word 0x00000000.
REQ-026 SHALL cover: start in lane 0 (txd 0x555555FB ctl 0x1 then 0xD5555555 ctl 0x0) -> header 2'b10, low word 0x55555578, high word 0xD5555555.
REQ-027 SHALL cover: data block 0x11223344,0x55667788 ctl 0 after start -> header 2'b01, payload unchanged, two valid cycles latency.
REQ-028 SHALL cover: i_tx_data_valid low for 3 cycles mid-block -> outputs frozen, block completes correctly after resume.
REQ-029 SHALL cover (ENCODER_TX_SM_EN): data block directly after idle -> error block (type 0x1E, codes 0x1E); without macro -> header 2'b01 data.
REQ-030 SHALL cover: i_reset_n asserted after phase-0 word -> outputs clear immediately; next block encodes from phase 0.

Source files
------------

// File: rtl/encoder.sv
// rtl/encoder.sv - 64b/66b transmit encoder on a 32-bit XGMII/PCS word path
// Optional TX block-sequence checker is compiled in when ENCODER_TX_SM_EN is defined.
module encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_txc,
  input  logic                    i_reset_n,
  input  logic                    i_init_done,
  input  logic [DATA_WIDTH-1:0]   i_txd,
  input  logic [DATA_WIDTH/8-1:0] i_txctl,
  input  logic                    i_tx_data_valid,
  output logic [DATA_WIDTH-1:0]   o_txd,
  output logic [1:0]              o_tx_header,
  output logic                    o_tx_header_valid
);

  localparam int DATA_NBYTES = DATA_WIDTH / 8;
  localparam int BLK_W       = 2 * DATA_WIDTH;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_ERR   = 8'hFE;
  localparam logic [7:0] CH_SEQ   = 8'h9C;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // Error block: type 0x1E followed by eight /E/ codes.
  localparam logic [63:0] EBLOCK = {{8{7'h1E}}, 8'h1E};

  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    term_type = 8'h87;
      3'd1:    term_type = 8'h99;
      3'd2:    term_type = 8'hAA;
      3'd3:    term_type = 8'hB4;
      3'd4:    term_type = 8'hCC;
      3'd5:    term_type = 8'hD2;
      3'd6:    term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
  endfunction

  logic                   phase_q, phase_d;
  logic [DATA_WIDTH-1:0]  held_txd_q, held_txd_d;
  logic [DATA_NBYTES-1:0] held_ctl_q, held_ctl_d;
  logic [BLK_W-1:0]       blk_pay_q, blk_pay_d;
  logic [1:0]             blk_hdr_q, blk_hdr_d;
  logic                   blk_vld_q, blk_vld_d;
  logic [DATA_WIDTH-1:0]  txd_q, txd_d;
  logic [1:0]             hdr_q, hdr_d;
  logic                   hdr_vld_q, hdr_vld_d;

  logic [BLK_W-1:0]         w;
  logic [2*DATA_NBYTES-1:0] c;
  logic [7:0]               code_ok;
  logic [55:0]              codes;
  logic [7:0]               term;
  logic                     lo_c, hi_c, lo_o, hi_o, lo_s, hi_s, hi_d;
  logic [1:0]               enc_hdr;
  logic [BLK_W-1:0]         enc_pay;
  logic                     enc_bad;
  logic [1:0]               out_hdr;
  logic [BLK_W-1:0]         out_pay;

  assign w = {i_txd, held_txd_q};
  assign c = {i_txctl, held_ctl_q};

  always_comb begin
    code_ok = '0;
    codes   = '0;
    term    = '0;
    for (int i = 0; i < 8; i++) begin
      code_ok[i]      = c[i] && (w[8*i +: 8] == CH_IDLE || w[8*i +: 8] == CH_ERR);
      codes[7*i +: 7] = (w[8*i +: 8] == CH_ERR) ? 7'h1E : 7'h00;
    end
    // Terminate in lane k: data below it, only idle/error codes above it.
    for (int k = 0; k < 8; k++) begin
      term[k] = c[k] && (w[8*k +: 8] == CH_TERM);
      for (int i = 0; i < 8; i++) begin
        if (i < k && c[i])        term[k] = 1'b0;
        if (i > k && !code_ok[i]) term[k] = 1'b0;
      end
    end
  end

  always_comb begin
    lo_c = &code_ok[3:0];
    hi_c = &code_ok[7:4];
    lo_o = (c[3:0] == 4'b0001) && (w[7:0] == CH_SEQ);
    hi_o = (c[7:4] == 4'b0001) && (w[39:32] == CH_SEQ);
    lo_s = (c[3:0] == 4'b0001) && (w[7:0] == CH_START);
    hi_s = (c[7:4] == 4'b0001) && (w[39:32] == CH_START);
    hi_d = (c[7:4] == 4'b0000);
  end

  always_comb begin
    enc_hdr = HDR_CTRL;
    enc_pay = EBLOCK;
    enc_bad = 1'b0;
    if (c == '0) begin
      enc_hdr = HDR_DATA;
      enc_pay = w;
    end else if (lo_c && hi_c) begin
      enc_pay = {codes, 8'h1E};
    end else if (lo_c && hi_o) begin
      enc_pay = {w[63:40], 4'h0, codes[27:0], 8'h2D};
    end else if (lo_c && hi_s) begin
      enc_pay = {w[63:40], 4'h0, codes[27:0], 8'h33};
    end else if (lo_o && hi_s) begin
      enc_pay = {w[63:40], 4'h0, 4'h0, w[31:8], 8'h66};
    end else if (lo_o && hi_o) begin
      enc_pay = {w[63:40], 4'h0, 4'h0, w[31:8], 8'h55};
    end else if (lo_s && hi_d) begin
      enc_pay = {w[63:8], 8'h78};
    end else if (lo_o && hi_c) begin
      enc_pay = {codes[55:28], 4'h0, w[31:8], 8'h4B};
    end else if (|term) begin
      enc_pay = '0;
      for (int k = 0; k < 8; k++) begin
        if (term[k]) begin
          enc_pay[7:0] = term_type(3'(k));
          for (int j = 0; j < 7; j++)
            if (j < k) enc_pay[8+8*j +: 8] = w[8*j +: 8];
          for (int j = 1; j < 8; j++)
            if (j > k) enc_pay[8+7*j +: 7] = codes[7*j +: 7];
        end
      end
    end else begin
      enc_bad = 1'b1;
    end
  end

`ifdef ENCODER_TX_SM_EN
  localparam logic [2:0] TX_INIT = 3'd0;
  localparam logic [2:0] TX_C    = 3'd1;
  localparam logic [2:0] TX_D    = 3'd2;
  localparam logic [2:0] TX_T    = 3'd3;
  localparam logic [2:0] TX_E    = 3'd4;

  localparam logic [2:0] CLS_C = 3'd0;
  localparam logic [2:0] CLS_S = 3'd1;
  localparam logic [2:0] CLS_D = 3'd2;
  localparam logic [2:0] CLS_T = 3'd3;
  localparam logic [2:0] CLS_E = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] sm_next;
  logic [2:0] blk_cls;
  logic       has_fe;

  // Any /E/ character makes the block an error-class block.
  always_comb begin
    has_fe = 1'b0;
    for (int i = 0; i < 8; i++)
      if (c[i] && w[8*i +: 8] == CH_ERR) has_fe = 1'b1;
    blk_cls = CLS_E;
    if (!enc_bad && !has_fe) begin
      if (enc_hdr == HDR_DATA) begin
        blk_cls = CLS_D;
      end else begin
        case (enc_pay[7:0])
          8'h1E, 8'h2D, 8'h4B, 8'h55: blk_cls = CLS_C;
          8'h33, 8'h66, 8'h78:        blk_cls = CLS_S;
          default:                    blk_cls = CLS_T;
        endcase
      end
    end
  end

  always_comb begin
    sm_next = TX_E;
    case (state_q)
      TX_D: begin
        if (blk_cls == CLS_D)      sm_next = TX_D;
        else if (blk_cls == CLS_T) sm_next = TX_T;
      end
      TX_E: begin
        case (blk_cls)
          CLS_D:   sm_next = TX_D;
          CLS_T:   sm_next = TX_T;
          CLS_C:   sm_next = TX_C;
          CLS_S:   sm_next = TX_D;
          default: sm_next = TX_E;
        endcase
      end
      default: begin
        if (blk_cls == CLS_C)      sm_next = TX_C;
        else if (blk_cls == CLS_S) sm_next = TX_D;
      end
    endcase
  end

  always_comb begin
    out_hdr = enc_hdr;
    out_pay = enc_pay;
    if (sm_next == TX_E) begin
      out_hdr = HDR_CTRL;
      out_pay = EBLOCK;
    end
  end
`else
  always_comb begin
    out_hdr = enc_hdr;
    out_pay = enc_pay;
  end
`endif

  always_comb begin
    phase_d    = phase_q;
    held_txd_d = held_txd_q;
    held_ctl_d = held_ctl_q;
    blk_pay_d  = blk_pay_q;
    blk_hdr_d  = blk_hdr_q;
    blk_vld_d  = blk_vld_q;
    txd_d      = txd_q;
    hdr_d      = hdr_q;
    hdr_vld_d  = hdr_vld_q;
`ifdef ENCODER_TX_SM_EN
    state_d    = state_q;
`endif
    if (!i_init_done) begin
      phase_d    = 1'b0;
      held_txd_d = '0;
      held_ctl_d = '0;
      blk_pay_d  = '0;
      blk_hdr_d  = '0;
      blk_vld_d  = 1'b0;
      txd_d      = '0;
      hdr_d      = '0;
      hdr_vld_d  = 1'b0;
`ifdef ENCODER_TX_SM_EN
      state_d    = TX_INIT;
`endif
    end else if (i_tx_data_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        held_txd_d = i_txd;
        held_ctl_d = i_txctl;
        if (blk_vld_q) begin
          txd_d     = blk_pay_q[DATA_WIDTH-1:0];
          hdr_d     = blk_hdr_q;
          hdr_vld_d = 1'b1;
        end
      end else begin
        // Old block's high half goes out on the same edge the new block is captured.
        blk_pay_d = out_pay;
        blk_hdr_d = out_hdr;
        blk_vld_d = 1'b1;
`ifdef ENCODER_TX_SM_EN
        state_d   = sm_next;
`endif
        if (blk_vld_q) begin
          txd_d     = blk_pay_q[BLK_W-1:DATA_WIDTH];
          hdr_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase_q    <= 1'b0;
      held_txd_q <= '0;
      held_ctl_q <= '0;
      blk_pay_q  <= '0;
      blk_hdr_q  <= '0;
      blk_vld_q  <= 1'b0;
      txd_q      <= '0;
      hdr_q      <= '0;
      hdr_vld_q  <= 1'b0;
`ifdef ENCODER_TX_SM_EN
      state_q    <= TX_INIT;
`endif
    end else begin
      phase_q    <= phase_d;
      held_txd_q <= held_txd_d;
      held_ctl_q <= held_ctl_d;
      blk_pay_q  <= blk_pay_d;
      blk_hdr_q  <= blk_hdr_d;
      blk_vld_q  <= blk_vld_d;
      txd_q      <= txd_d;
      hdr_q      <= hdr_d;
      hdr_vld_q  <= hdr_vld_d;
`ifdef ENCODER_TX_SM_EN
      state_q    <= state_d;
`endif
    end
  end

  assign o_txd             = txd_q;
  assign o_tx_header       = hdr_q;
  assign o_tx_header_valid = hdr_vld_q;

endmodule

// File: tb/tb_encoder.sv
// tb/tb_encoder.sv - directed self-checking bench for encoder
// Expectations follow ENCODER_TX_SM_EN when the macro is defined.
module tb_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        valid;
  logic [31:0] txd;
  logic [3:0]  ctl;
  logic [31:0] o_txd;
  logic [1:0]  o_hdr;
  logic        o_hv;

  int n_checks = 0;
  int n_errors = 0;

  logic        p_vld;
  logic [1:0]  p_hdr;
  logic [31:0] p_lo, p_hi;
  string       p_tag;

  localparam logic [31:0] IDLE  = 32'h07070707;
  localparam logic [31:0] EB_LO = 32'hC78F1E1E;
  localparam logic [31:0] EB_HI = 32'h3C78F1E3;

  encoder dut (
    .i_txc             (clk),
    .i_reset_n         (rst_n),
    .i_init_done       (init_done),
    .i_txd             (txd),
    .i_txctl           (ctl),
    .i_tx_data_valid   (valid),
    .o_txd             (o_txd),
    .o_tx_header       (o_hdr),
    .o_tx_header_valid (o_hv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one 64b XGMII word as two halves; checks the previous block on the way out.
  task automatic send_block(input string tag, input logic [31:0] lo, input logic [3:0] lc,
                            input logic [31:0] hi, input logic [3:0] hc,
                            input logic [1:0] eh, input logic [31:0] elo, input logic [31:0] ehi,
                            input int stall);
    logic [34:0] exp0, exp1;
    exp0 = p_vld ? {1'b1, p_hdr, p_lo} : 35'd0;
    exp1 = p_vld ? {1'b0, p_hdr, p_hi} : 35'd0;
    txd = lo; ctl = lc; valid = 1'b1;
    @(posedge clk); #1;
    check({p_tag, "/lo"}, 64'({o_hv, o_hdr, o_txd}), 64'(exp0));
    valid = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      check({p_tag, "/frozen"}, 64'({o_hv, o_hdr, o_txd}), 64'(exp0));
    end
    txd = hi; ctl = hc; valid = 1'b1;
    @(posedge clk); #1;
    check({p_tag, "/hi"}, 64'({o_hv, o_hdr, o_txd}), 64'(exp1));
    valid = 1'b0;
    p_vld = 1'b1; p_hdr = eh; p_lo = elo; p_hi = ehi; p_tag = tag;
  endtask

  task automatic send_idle(input string tag);
    send_block(tag, IDLE, 4'hF, IDLE, 4'hF, 2'b10, 32'h0000001E, 32'h0, 0);
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; valid = 1'b0; txd = '0; ctl = '0;
    p_vld = 1'b0; p_hdr = '0; p_lo = '0; p_hi = '0; p_tag = "none";
    repeat (3) @(posedge clk);
    #1;
    check("reset", 64'({o_hv, o_hdr, o_txd}), 64'd0);
    rst_n = 1'b1;

    txd = IDLE; ctl = 4'hF; valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_hold", 64'({o_hv, o_hdr, o_txd}), 64'd0);
    valid = 1'b0;
    init_done = 1'b1;

    send_idle("idle");
    send_block("s0", 32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 2'b10, 32'h55555578, 32'hD5555555, 0);
    send_block("data", 32'h11223344, 4'h0, 32'h55667788, 4'h0, 2'b01, 32'h11223344, 32'h55667788, 0);
    send_block("stall", 32'hAABBCCDD, 4'h0, 32'hEEFF0011, 4'h0, 2'b01, 32'hAABBCCDD, 32'hEEFF0011, 3);
    send_block("t3", 32'hFD332211, 4'h8, IDLE, 4'hF, 2'b10, 32'h332211B4, 32'h0, 0);
    send_idle("idle2");
`ifdef ENCODER_TX_SM_EN
    send_block("fe_idle", 32'h0707FE07, 4'hF, IDLE, 4'hF, 2'b10, EB_LO, EB_HI, 0);
`else
    send_block("fe_idle", 32'h0707FE07, 4'hF, IDLE, 4'hF, 2'b10, 32'h000F001E, 32'h0, 0);
`endif
    send_idle("idle3");
`ifdef ENCODER_TX_SM_EN
    send_block("d_after_idle", 32'h01020304, 4'h0, 32'h05060708, 4'h0, 2'b10, EB_LO, EB_HI, 0);
`else
    send_block("d_after_idle", 32'h01020304, 4'h0, 32'h05060708, 4'h0, 2'b01, 32'h01020304, 32'h05060708, 0);
`endif
    send_idle("idle4");
    send_block("start_l2", 32'h55FB5555, 4'h4, 32'h55555555, 4'h0, 2'b10, EB_LO, EB_HI, 0);
    send_idle("idle5");
    send_block("o0", 32'h0200019C, 4'h1, IDLE, 4'hF, 2'b10, 32'h0200014B, 32'h0, 0);
    send_block("s4", IDLE, 4'hF, 32'h555555FB, 4'h1, 2'b10, 32'h00000033, 32'h55555500, 0);
    send_block("data2", 32'hDEADBEEF, 4'h0, 32'hCAFEF00D, 4'h0, 2'b01, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    send_block("t0", 32'h070707FD, 4'hF, IDLE, 4'hF, 2'b10, 32'h00000087, 32'h0, 0);
    send_idle("idle6");

    init_done = 1'b0; txd = IDLE; ctl = 4'hF; valid = 1'b1;
    @(posedge clk); #1;
    check("init_drop", 64'({o_hv, o_hdr, o_txd}), 64'd0);
    valid = 1'b0; init_done = 1'b1; p_vld = 1'b0; p_tag = "after_init";
    send_idle("idle7");

    txd = 32'h555555FB; ctl = 4'h1; valid = 1'b1;
    @(posedge clk); #1;
    check("rst_pre", 64'({o_hv, o_hdr, o_txd}), 64'({1'b1, 2'b10, 32'h0000001E}));
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({o_hv, o_hdr, o_txd}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; p_vld = 1'b0; p_tag = "after_rst";

    send_idle("idle8");
    send_block("s0b", 32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 2'b10, 32'h55555578, 32'hD5555555, 0);
    send_block("data3", 32'h0BADF00D, 4'h0, 32'h12345678, 4'h0, 2'b01, 32'h0BADF00D, 32'h12345678, 0);
    send_block("t0b", 32'h070707FD, 4'hF, IDLE, 4'hF, 2'b10, 32'h00000087, 32'h0, 0);
    send_idle("idle9");
    send_idle("flush");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
